// File: rtl/mult_div_unit.sv
// Multi-cycle signed multiply/divide unit: shift-add multiply, restoring divide, HI/LO result registers.
// Optional macro MDU_UNSIGNED_EN adds an Unsigned input for multu/divu.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [3:0]       ALU_Control,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
`ifdef MDU_UNSIGNED_EN
    input  logic             Unsigned,
`endif
    output logic             Busy,
    output logic             Done,
    output logic             DivByZero,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam logic [3:0] OP_MULT = 4'b0101;
    localparam logic [3:0] OP_DIV  = 4'b1011;
    localparam int         CW      = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t           state_q, state_d;
    logic             load;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] hi_w, lo_w, m_q;
    logic             op_div_q, neg_q, nega_q, bz_q;

    logic             is_unsigned;
`ifdef MDU_UNSIGNED_EN
    assign is_unsigned = Unsigned;
`else
    assign is_unsigned = 1'b0;
`endif

    logic             is_div_code, valid_code, sa, sb;
    logic [WIDTH-1:0] abs_a, abs_b;

    assign is_div_code = (ALU_Control == OP_DIV);
    assign valid_code  = is_div_code || (ALU_Control == OP_MULT);
    assign sa          = ~is_unsigned & A[WIDTH-1];
    assign sb          = ~is_unsigned & B[WIDTH-1];
    assign abs_a       = sa ? -A : A;
    assign abs_b       = sb ? -B : B;

    // One iteration step: multiply adds the multiplicand into the high half when the
    // current multiplier bit is set; divide trial-subtracts the divisor from the shifted remainder.
    logic [WIDTH:0]   sum, shifted;
    logic             ge;
    logic [WIDTH-1:0] rem_next;

    assign sum      = {1'b0, hi_w} + (lo_w[0] ? {1'b0, m_q} : '0);
    assign shifted  = {hi_w, lo_w[WIDTH-1]};
    assign ge       = (shifted >= {1'b0, m_q});
    assign rem_next = ge ? (shifted[WIDTH-1:0] - m_q) : shifted[WIDTH-1:0];

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   q_fix, r_fix;

    assign prod_fix = neg_q  ? -{hi_w, lo_w} : {hi_w, lo_w};
    assign q_fix    = neg_q  ? -lo_w : lo_w;
    assign r_fix    = nega_q ? -hi_w : hi_w;

    assign Busy = (state_q != IDLE);

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            IDLE: if (Start && valid_code) begin
                state_d = RUN;
                load    = 1'b1;
            end
            RUN:  if (cnt == CW'(WIDTH - 1)) state_d = FIX;
            FIX:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; the whole datapath is
    // reset because an aborted operation must leave no stale operands behind.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= IDLE;
            cnt       <= '0;
            hi_w      <= '0;
            lo_w      <= '0;
            m_q       <= '0;
            op_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            nega_q    <= 1'b0;
            bz_q      <= 1'b0;
            HI        <= '0;
            LO        <= '0;
            Done      <= 1'b0;
            DivByZero <= 1'b0;
        end else begin
            state_q   <= state_d;
            Done      <= 1'b0;
            DivByZero <= 1'b0;
            case (state_q)
                IDLE: if (load) begin
                    op_div_q <= is_div_code;
                    neg_q    <= sa ^ sb;
                    nega_q   <= sa;
                    bz_q     <= (B == '0);
                    cnt      <= '0;
                    hi_w     <= '0;
                    m_q      <= is_div_code ? abs_b : abs_a;
                    lo_w     <= is_div_code ? abs_a : abs_b;
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    if (op_div_q) begin
                        hi_w <= rem_next;
                        lo_w <= {lo_w[WIDTH-2:0], ge};
                    end else begin
                        hi_w <= sum[WIDTH:1];
                        lo_w <= {sum[0], lo_w[WIDTH-1:1]};
                    end
                end
                FIX: begin
                    Done <= 1'b1;
                    if (op_div_q) begin
                        // With a zero divisor every trial subtract succeeds, so the
                        // remainder ends as |A| and sign correction restores A itself.
                        LO        <= bz_q ? '1 : q_fix;
                        HI        <= r_fix;
                        DivByZero <= bz_q;
                    end else begin
                        {HI, LO} <= prod_fix;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
